dot_product_seq: RTL and testbench

Sequential controller that computes a dot product with one shared multiply-accumulate unit, one element pair per accepted beat.
- A start pulse opens a job. LEN element pairs are then streamed in over a valid/ready handshake.
- The result is held on a valid/ready output until the consumer takes it.
- It is the area-lean replacement for the fully parallel dot-product datapath, and its result width matches that datapath (2*W).

---
 rtl/dot_product_seq.sv | 119 +++++++++++
 tb/tb_dot_product_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_seq.sv
// Sequential dot product: one shared multiply-accumulate, one element pair per accepted beat.
// Build option DOT_PRODUCT_SEQ_SAT_EN saturates the result on overflow instead of wrapping.
module dot_product_seq #(
    parameter int W   = 8,
    parameter int LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             a_in,
    input  logic [W-1:0]             b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           result,
    output logic                     overflow,
    output logic                     busy,
    output logic [$clog2(LEN)-1:0]   elem_idx
);

    localparam int IW = $clog2(LEN);
    localparam int AW = 2*W + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
    localparam logic [AW-1:0] RES_MAX  = {{IW{1'b0}}, {(2*W){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [2*W-1:0]    result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [2*W-1:0]    prod;
    logic [AW-1:0]     acc_sum;
    logic              sum_ovf;
    logic [2*W-1:0]    sum_res;

    assign prod    = a_in * b_in;
    assign acc_sum = acc_q + AW'(prod);
    assign sum_ovf = (acc_sum > RES_MAX);

`ifdef DOT_PRODUCT_SEQ_SAT_EN
    assign sum_res = sum_ovf ? {(2*W){1'b1}} : acc_sum[2*W-1:0];
`else
    assign sum_res = acc_sum[2*W-1:0];
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = acc_sum;
                    if (idx_q == LAST_IDX) begin
                        // Result and flag are captured on the final beat so they stay stable in DONE.
                        idx_d    = '0;
                        result_d = sum_res;
                        ovf_d    = sum_ovf;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);
    assign elem_idx = idx_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed self-checking bench for dot_product_seq (W=8, LEN=8).
// Expected results are hand-computed; the saturated value is used when DOT_PRODUCT_SEQ_SAT_EN is defined.
module tb_dot_product_seq;

    localparam int W   = 8;
    localparam int LEN = 8;

`ifdef DOT_PRODUCT_SEQ_SAT_EN
    localparam logic [15:0] EXP_OVF_RES = 16'd65535;
`else
    localparam logic [15:0] EXP_OVF_RES = 16'd61448;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           overflow;
    logic           busy;
    logic [2:0]     elem_idx;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] va [LEN];
    logic [W-1:0] vb [LEN];

    dot_product_seq #(.W(W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy),
        .elem_idx  (elem_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: a=1..8, b=8..1 (120); kind 1: a=b=1..8 (204); kind 2: all 255 (520200)
    task automatic set_vec(input int kind);
        for (int i = 0; i < LEN; i++) begin
            case (kind)
                0:       begin va[i] = W'(i + 1); vb[i] = W'(LEN - i); end
                1:       begin va[i] = W'(i + 1); vb[i] = W'(i + 1);   end
                default: begin va[i] = 8'd255;    vb[i] = 8'd255;      end
            endcase
        end
    endtask

    task automatic start_job();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_accum", in_ready, 1);
    endtask

    task automatic stream(input bit stalls, input bit poke_start);
        for (int i = 0; i < LEN; i++) begin
            if (stalls && i > 0) begin
                in_valid = 1'b0;
                repeat ((i % 3) + 1) begin
                    step();
                    check("idx_stall", elem_idx, i);
                end
            end
            in_valid = 1'b1;
            a_in     = va[i];
            b_in     = vb[i];
            if (poke_start && i == 3) start = 1'b1;
            check("no_out_valid_mid", out_valid, 0);
            step();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input logic [15:0] exp_res, input logic exp_ovf, input int hold);
        check("out_valid_rise", out_valid, 1);
        check("result", result, exp_res);
        check("overflow", overflow, exp_ovf);
        check("in_ready_done", in_ready, 0);
        check("idx_done", elem_idx, 0);
        repeat (hold) begin
            step();
            check("out_valid_hold", out_valid, 1);
            check("result_hold", result, exp_res);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("busy_after_hs", busy, 0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idx", elem_idx, 0);
        rst = 1'b0;

        // in_valid in IDLE is not accepted
        in_valid = 1'b1;
        a_in     = 8'd100;
        b_in     = 8'd100;
        check("idle_in_ready", in_ready, 0);
        step();
        step();
        check("idle_idx", elem_idx, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Basic job
        set_vec(0);
        start_job();
        stream(1'b0, 1'b0);
        finish_job(16'd120, 1'b0, 1);

        // Stalls between beats and 5 cycles of backpressure
        start_job();
        stream(1'b1, 1'b0);
        finish_job(16'd120, 1'b0, 5);

        // start during ACCUM is ignored
        start_job();
        stream(1'b0, 1'b1);
        finish_job(16'd120, 1'b0, 0);

        // Overflow
        set_vec(2);
        start_job();
        stream(1'b0, 1'b0);
        finish_job(EXP_OVF_RES, 1'b1, 1);

        // Reset after beat 4
        set_vec(0);
        start_job();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a_in     = va[i];
            b_in     = vb[i];
            step();
        end
        check("idx_after_4", elem_idx, 4);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_idx", elem_idx, 0);
        rst = 1'b0;
        set_vec(1);
        start_job();
        stream(1'b0, 1'b0);
        finish_job(16'd204, 1'b0, 1);

        // Back-to-back: start coinciding with the handshake is ignored, the next cycle is honoured
        set_vec(0);
        start_job();
        stream(1'b0, 1'b0);
        check("b2b_first_valid", out_valid, 1);
        check("b2b_first_result", result, 120);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_idle_after_hs", busy, 0);
        step();
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        set_vec(1);
        stream(1'b0, 1'b0);
        finish_job(16'd204, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
